// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader state encoding and word-framing constants
package cpu_pkg;

    typedef enum logic [3:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        SUM_HI,
        SUM_LO,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/ram_program_loader.sv
// rtl/ram_program_loader.sv - framed byte-stream loader writing RAM port B, holds CPU in reset until checksum verifies
module ram_program_loader
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  we_b,
    output logic                  CpuRst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(1) << ADDR_WIDTH;

    loader_state_t state, state_nxt;
    logic [CNT_W-1:0]      count, count_nxt;
    logic [7:0]            hi_byte, hi_byte_nxt;
    logic [7:0]            rx_sum_hi, rx_sum_hi_nxt;
    logic [DATA_WIDTH-1:0] sum, sum_nxt;
    logic [DATA_WIDTH-1:0] data_b_nxt;
    logic [ADDR_WIDTH-1:0] addr_b_nxt;
    logic [ADDR_WIDTH:0]   words_nxt;
    logic                  in_ready_nxt, we_b_nxt, cpu_rst_nxt, done_nxt, error_nxt;
    logic                  accept;
    logic [CNT_W-1:0]      full_count;

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        hi_byte_nxt   = hi_byte;
        rx_sum_hi_nxt = rx_sum_hi;
        sum_nxt       = sum;
        data_b_nxt    = data_b;
        addr_b_nxt    = addr_b;
        words_nxt     = words_loaded;
        accept        = in_valid && in_ready;
        full_count    = {count[15:8], in_byte};

        case (state)
            HDR_HI: if (accept) begin
                count_nxt[15:8] = in_byte;
                state_nxt       = HDR_LO;
            end
            HDR_LO: if (accept) begin
                count_nxt[7:0] = in_byte;
                if ({1'b0, full_count} > MAX_WORDS)
                    state_nxt = ERROR;
                else if (full_count == '0)
                    state_nxt = SUM_HI;
                else
                    state_nxt = DAT_HI;
            end
            DAT_HI: if (accept) begin
                hi_byte_nxt = in_byte;
                state_nxt   = DAT_LO;
            end
            DAT_LO: if (accept) begin
                data_b_nxt = {hi_byte, in_byte};
                addr_b_nxt = words_loaded[ADDR_WIDTH-1:0];
                state_nxt  = WRITE;
            end
            WRITE: begin
                // The write pulse is already on we_b; account for it and pick the next field.
                sum_nxt   = sum + data_b;
                words_nxt = words_loaded + 1'b1;
                if ({{(CNT_W-ADDR_WIDTH-1){1'b0}}, words_nxt} == count)
                    state_nxt = SUM_HI;
                else
                    state_nxt = DAT_HI;
            end
            SUM_HI: if (accept) begin
                rx_sum_hi_nxt = in_byte;
                state_nxt     = SUM_LO;
            end
            SUM_LO: if (accept) begin
                state_nxt = ({rx_sum_hi, in_byte} == sum) ? DONE : ERROR;
            end
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = HDR_HI;
        endcase

        // Status outputs are registered versions of what the next state implies.
        in_ready_nxt = (state_nxt != WRITE) && (state_nxt != DONE) && (state_nxt != ERROR);
        we_b_nxt     = (state_nxt == WRITE);
        done_nxt     = (state_nxt == DONE);
        error_nxt    = (state_nxt == ERROR);
        cpu_rst_nxt  = (state_nxt != DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= HDR_HI;
            count        <= '0;
            hi_byte      <= '0;
            rx_sum_hi    <= '0;
            sum          <= '0;
            data_b       <= '0;
            addr_b       <= '0;
            words_loaded <= '0;
            in_ready     <= 1'b1;
            we_b         <= 1'b0;
            CpuRst       <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            hi_byte      <= hi_byte_nxt;
            rx_sum_hi    <= rx_sum_hi_nxt;
            sum          <= sum_nxt;
            data_b       <= data_b_nxt;
            addr_b       <= addr_b_nxt;
            words_loaded <= words_nxt;
            in_ready     <= in_ready_nxt;
            we_b         <= we_b_nxt;
            CpuRst       <= cpu_rst_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
        end
    end

endmodule

// File: tb/tb_ram_program_loader.sv
// tb/tb_ram_program_loader.sv - directed-vector bench for ram_program_loader
module tb_ram_program_loader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_b;
    logic [9:0]  addr_b;
    logic        we_b;
    logic        CpuRst;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    int n_vec = 0;
    int n_miscmp = 0;
    int n_writes = 0;
    logic [9:0]  last_addr = '0;
    logic [15:0] ram_model [0:1023];

    ram_program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
        .Clk(Clk), .Rst(Rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .data_b(data_b), .addr_b(addr_b), .we_b(we_b),
        .CpuRst(CpuRst), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    // RAM port B model: each one-cycle we_b pulse is seen on exactly one falling edge.
    always @(negedge Clk) begin
        if (we_b) begin
            ram_model[addr_b] = data_b;
            last_addr = addr_b;
            n_writes++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        in_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        n_writes = 0;
    endtask

    // Returns at the falling edge just after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_byte = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge Clk);
    endtask

    initial begin
        do_reset();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_cpurst", {31'b0, CpuRst}, 32'd1);
        chk("rst_we_b", {31'b0, we_b}, 32'd0);
        chk("rst_data_b", {16'b0, data_b}, 32'h0);
        chk("rst_addr_b", {22'b0, addr_b}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_words", {21'b0, words_loaded}, 32'd0);

        // Two-word frame, good checksum.
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        chk("f1_we0", {31'b0, we_b}, 32'd1);
        chk("f1_addr0", {22'b0, addr_b}, 32'h0);
        chk("f1_data0", {16'b0, data_b}, 32'h1234);
        chk("f1_ready_write", {31'b0, in_ready}, 32'd0);
        send_byte(8'hAB); send_byte(8'hCD);
        chk("f1_we1", {31'b0, we_b}, 32'd1);
        chk("f1_addr1", {22'b0, addr_b}, 32'h1);
        send_byte(8'hBE); send_byte(8'h01);
        in_valid = 1'b0;
        chk("f1_ram0", {16'b0, ram_model[0]}, 32'h1234);
        chk("f1_ram1", {16'b0, ram_model[1]}, 32'hABCD);
        chk("f1_writes", n_writes, 32'd2);
        chk("f1_done", {31'b0, done}, 32'd1);
        chk("f1_cpurst", {31'b0, CpuRst}, 32'd0);
        chk("f1_words", {21'b0, words_loaded}, 32'd2);
        chk("f1_error", {31'b0, error}, 32'd0);
        chk("f1_we_idle", {31'b0, we_b}, 32'd0);

        // Same frame, bad checksum.
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'hBE); send_byte(8'h00);
        in_valid = 1'b0;
        chk("f2_error", {31'b0, error}, 32'd1);
        chk("f2_done", {31'b0, done}, 32'd0);
        chk("f2_cpurst", {31'b0, CpuRst}, 32'd1);
        chk("f2_ready", {31'b0, in_ready}, 32'd0);

        // Empty image.
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        in_valid = 1'b0;
        chk("f3_writes", n_writes, 32'd0);
        chk("f3_done", {31'b0, done}, 32'd1);
        chk("f3_cpurst", {31'b0, CpuRst}, 32'd0);

        // Count one past capacity.
        do_reset();
        send_byte(8'h04); send_byte(8'h01);
        in_valid = 1'b0;
        chk("f4_error", {31'b0, error}, 32'd1);
        chk("f4_ready", {31'b0, in_ready}, 32'd0);
        repeat (3) @(negedge Clk);
        chk("f4_writes", n_writes, 32'd0);

        // Full-capacity image of 1024 words of 0x0001.
        do_reset();
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            send_byte(8'h00); send_byte(8'h01);
        end
        send_byte(8'h04); send_byte(8'h00);
        in_valid = 1'b0;
        chk("f5_last_addr", {22'b0, last_addr}, 32'h3FF);
        chk("f5_writes", n_writes, 32'd1024);
        chk("f5_done", {31'b0, done}, 32'd1);
        chk("f5_words", {21'b0, words_loaded}, 32'd1024);

        // Reset asserted during the WRITE cycle of word 1.
        do_reset();
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        chk("f6_in_write", {31'b0, we_b}, 32'd1);
        Rst = 1'b1;
        in_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        chk("f6_we_b", {31'b0, we_b}, 32'd0);
        chk("f6_ready", {31'b0, in_ready}, 32'd1);
        chk("f6_cpurst", {31'b0, CpuRst}, 32'd1);
        chk("f6_words", {21'b0, words_loaded}, 32'd0);

        // Fresh load with a 5-cycle in_valid gap inside word 1.
        n_writes = 0;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("f7_gap_we", {31'b0, we_b}, 32'd0);
            chk("f7_gap_ready", {31'b0, in_ready}, 32'd1);
            @(negedge Clk);
        end
        chk("f7_gap_words", {21'b0, words_loaded}, 32'd1);
        chk("f7_gap_writes", n_writes, 32'd1);
        send_byte(8'h07);
        chk("f7_we1", {31'b0, we_b}, 32'd1);
        send_byte(8'h00); send_byte(8'h0C);
        in_valid = 1'b0;
        chk("f7_ram0", {16'b0, ram_model[0]}, 32'h0005);
        chk("f7_ram1", {16'b0, ram_model[1]}, 32'h0007);
        chk("f7_words", {21'b0, words_loaded}, 32'd2);
        chk("f7_done", {31'b0, done}, 32'd1);
        chk("f7_cpurst", {31'b0, CpuRst}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Writer on RAM port B, the port the CPU leaves idle. The CPU only reads instructions and data through port A.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 16-bit words. Each word is written sequentially into RAM port B starting at address 0.
- Holds the CPU in reset until the image is loaded and its checksum verifies.
- Sits beside the CPU top level. Its outputs drive RAM data_b, addr_b and we_b, plus the CPU's Rst.

Parameters:
- DATA_WIDTH, 16, RAM word width. The design is fixed at 2 bytes per word.
- ADDR_WIDTH, 10, RAM address width. Maximum image size is 2^ADDR_WIDTH words.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset: one clock; reset is synchronous and active-high.
- in_byte  in  8  stream data byte.
- in_valid  in  1  in_byte is valid this cycle.
- in_ready  out  1  loader accepts in_byte this cycle; a transfer occurs when in_valid and in_ready are both high.
- data_b  out  DATA_WIDTH  RAM port B write data.
- addr_b  out  ADDR_WIDTH  RAM port B address.
- we_b  out  1  RAM port B write enable, single-cycle pulse.
- CpuRst  out  1  reset to the CPU; high until load succeeds.
- done  out  1  load completed and checksum matched; sticky.
- error  out  1  bad word count or checksum mismatch; sticky.
- words_loaded  out  ADDR_WIDTH+1  number of words written so far.

Behaviour:
- Frame format: CNT_HI, CNT_LO, then N words as HI byte followed by LO byte, then SUM_HI, SUM_LO.
  - N is the 16-bit word count.
  - SUM is the sum of all N words, mod 2^16.
- All outputs are registered.
- Reset values:
  - state=HDR_HI, in_ready=1, CpuRst=1.
  - data_b=0, addr_b=0, we_b=0.
  - done=0, error=0, words_loaded=0.
  - Internal count and sum registers are cleared.
- States and transitions (advance only on an accepted byte unless noted):
  - HDR_HI: latch count[15:8] -> HDR_LO.
  - HDR_LO: latch count[7:0].
    - If full count > 2^ADDR_WIDTH -> ERROR.
    - Else if count == 0 -> SUM_HI.
    - Else -> DAT_HI.
  - DAT_HI: latch word[15:8] -> DAT_LO.
  - DAT_LO: on accept, register data_b={hi,byte} and addr_b=words_loaded[ADDR_WIDTH-1:0]; we_b=1 on the next cycle -> WRITE.
  - WRITE (exactly one cycle, unconditional):
    - we_b is high for this cycle only.
    - sum += data_b; words_loaded += 1.
    - If words_loaded+1 == count -> SUM_HI, else -> DAT_HI.
  - SUM_HI: latch rx_sum[15:8] -> SUM_LO.
  - SUM_LO: compare {rx_sum_hi, byte} with sum.
    - Equal -> DONE.
    - Not equal -> ERROR.
  - DONE: done=1, CpuRst=0 from the first cycle in DONE. Terminal until Rst.
  - ERROR: error=1, CpuRst stays 1. Terminal until Rst.
- in_ready:
  - 1 in HDR_*, DAT_*, SUM_*.
  - 0 in WRITE, DONE, ERROR.
  - Bytes offered while in_ready=0 are not consumed; the source holds them.
- Latency: the RAM write pulse occurs exactly one cycle after the LO byte is accepted. Maximum throughput is one word per 3 cycles.
- Word-count boundaries:
  - Count exactly 2^ADDR_WIDTH is legal; the last write goes to address 2^ADDR_WIDTH-1.
  - addr_b never wraps.
- Outside WRITE, we_b=0 and data_b/addr_b hold their last values.
- Rst asserted in any state, including WRITE, forces reset values on the next edge. we_b drops to 0 immediately, with no partial completion, and CpuRst returns to 1.
- Sum arithmetic is 16-bit and wraps modulo 2^16. The count comparison uses the full 16-bit count.

Decomposition:
- Shared package (cpu_pkg): loader state enum (HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, SUM_HI, SUM_LO, DONE, ERROR) and a BYTES_PER_WORD=2 constant.
- No sub-module is needed; the FSM, the byte assembler and the checksum accumulator sit in a single module.
- Top-level integration:
  - CPU Rst = Rst | CpuRst.
  - RAM data_b/addr_b/we_b come from this block.

Test Plan:
- Bytes 00 02 12 34 AB CD BE 01, in_valid held high:
  - Result: RAM[0]=0x1234, RAM[1]=0xABCD.
  - we_b pulses twice, each one cycle after bytes 34 and CD.
  - done=1, CpuRst=0, words_loaded=2, error=0.
- Same frame with trailer BE 00 -> error=1, done=0, CpuRst=1, in_ready=0.
- Bytes 00 00 00 00 (N=0, SUM=0) -> no we_b pulses, done=1, CpuRst=0.
- Header 04 01 (N=1025 > 1024) -> error=1 after CNT_LO, no writes.
- Header 04 00 followed by 1024 words 0x0001 and SUM 04 00 -> last write addr_b=0x3FF, done=1, words_loaded=1024.
- Two further cases in one run:
  - Assert Rst during the WRITE cycle of word 1 -> we_b=0 next cycle, state HDR_HI, CpuRst=1, words_loaded=0.
  - Drop in_valid for 5 cycles mid-word -> no state change and no write; the load resumes correctly.
